// File: rtl/data_memory.sv
// Word-addressed 16-bit data memory with a programmable number of wait states.
// One transaction in flight at a time; out-of-range addresses fault instead of aliasing.
module data_memory #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r_en,
    input  logic [15:0] mem_r_addr,
    output logic [15:0] mem_r_data,
    input  logic        mem_w_en,
    input  logic [15:0] mem_w_addr,
    input  logic [15:0] mem_w_data,
    output logic        mem_busy,
    output logic        mem_r_valid,
    output logic        mem_w_done,
    output logic        mem_fault
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [15:0] mem_q [2**ADDR_W];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        r_en_q, w_en_q;
    logic [15:0] r_addr_q, w_addr_q, w_data_q;
    logic [15:0] r_data_q;
    logic        r_valid_q, w_done_q, fault_q, busy_q;

    logic        req, accept, commit;
    logic        txn_r_en, txn_w_en;
    logic [15:0] txn_r_addr, txn_w_addr, txn_w_data;
    logic        r_oor, w_oor;
    logic [15:0] rd_value;

    // With zero wait states the commit happens on the accepting edge, so the
    // transaction is taken straight from the ports instead of the latches.
    always_comb begin
        req        = mem_r_en | mem_w_en;
        accept     = req && (state_q == IDLE || state_q == RESP);
        txn_r_en   = accept ? mem_r_en   : r_en_q;
        txn_w_en   = accept ? mem_w_en   : w_en_q;
        txn_r_addr = accept ? mem_r_addr : r_addr_q;
        txn_w_addr = accept ? mem_w_addr : w_addr_q;
        txn_w_data = accept ? mem_w_data : w_data_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        r_oor = (txn_r_addr[15:ADDR_W] != '0);
        w_oor = (txn_w_addr[15:ADDR_W] != '0);

        // Write commits before the read, so a matching address reads the new data.
        if (r_oor) begin
            rd_value = 16'h0000;
        end else if (txn_w_en && !w_oor && (txn_r_addr == txn_w_addr)) begin
            rd_value = txn_w_data;
        end else begin
            rd_value = mem_q[txn_r_addr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            r_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            r_addr_q  <= 16'h0000;
            w_addr_q  <= 16'h0000;
            w_data_q  <= 16'h0000;
            r_data_q  <= 16'h0000;
            r_valid_q <= 1'b0;
            w_done_q  <= 1'b0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                r_en_q   <= mem_r_en;
                w_en_q   <= mem_w_en;
                r_addr_q <= mem_r_addr;
                w_addr_q <= mem_w_addr;
                w_data_q <= mem_w_data;
            end
            r_valid_q <= commit & txn_r_en;
            w_done_q  <= commit & txn_w_en;
            fault_q   <= commit & ((txn_r_en & r_oor) | (txn_w_en & w_oor));
            busy_q    <= (state_d == WAIT);
            if (commit && txn_r_en) begin
                r_data_q <= rd_value;
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (commit && txn_w_en && !w_oor) begin
            mem_q[txn_w_addr[ADDR_W-1:0]] <= txn_w_data;
        end
    end

    assign mem_r_data  = r_data_q;
    assign mem_r_valid = r_valid_q;
    assign mem_w_done  = w_done_q;
    assign mem_fault   = fault_q;
    assign mem_busy    = busy_q;

endmodule
